cdc_handshake_mc: RTL and testbench
===================================

Name: cdc_handshake_mc

Overview:
Multi-channel cross-domain handshake. NUM_CH independent request/ack channels in src_clk share one data path into dst_clk. Transfers are serialised through a forward async_fifo carrying {channel, data}. Acks return through a reverse async_fifo carrying the channel id. Replaces per-channel single-bit handshakes in register/command paths; each channel keeps full-handshake semantics, and different channels can have transfers in flight at the same time.

Parameters:
WIDTH, 8, payload bits per channel
NUM_CH, 4, number of source channels (1..16)
CH_W, derived = max(1, clog2(NUM_CH)), channel-id width (localparam)
FIFO_DEPTH_LOG2, derived = max(1, clog2(NUM_CH)), depth of both async_fifos (localparam; guarantees depth >= NUM_CH)

Ports:
rst  in  1  asynchronous, active-high reset, both domains
src_clk  in  1  source clock
src  in  NUM_CH*WIDTH  payloads; channel c occupies bits [c*WIDTH +: WIDTH]
src_val  in  NUM_CH  per-channel request
src_ack  out  NUM_CH  per-channel one-cycle completion pulse (src_clk)
dst_clk  in  1  destination clock
dst  out  WIDTH  delivered payload
dst_ch  out  CH_W  channel id of dst
dst_val  out  1  payload valid (level)
dst_ack  in  1  consumer accept

Behaviour:
- Reset (async): all channel FSMs go IDLE; arbiter pointer = 0. src_ack=0, dst=0, dst_ch=0, dst_val=0. Both FIFOs are emptied. A reset mid-transfer discards everything in flight, and no src_ack is issued for it.
- Per-channel source FSM (src_clk), states IDLE/PEND/WAIT:
  - IDLE: if src_val[c], capture src slice c into hold reg c and go PEND. src_val may drop after the capture cycle.
  - PEND: eligible for arbitration. When granted and fwd FIFO !full, wr_en with {c, hold[c]} and go WAIT.
  - WAIT: when the reverse FIFO pops with id==c, pulse src_ack[c] for that cycle and go IDLE.
  - A new request on c is sampled the cycle after the ack at the earliest.
- Arbiter: round-robin over PEND channels. At most one grant per cycle. After a write, the pointer moves to winner+1 (mod NUM_CH). No grant while fwd FIFO is full.
- Reverse FIFO pop (src side):
  - rd_en whenever !empty, one entry per two cycles (pop, then consume registered dout).
  - An id whose channel is not in WAIT is dropped silently (cannot occur in correct operation; the bench checks it never happens).
- Destination FSM (dst_clk), states IDLE/FIFO_RD/DATA_READY:
  - IDLE: if fwd FIFO !empty, rd_en and go FIFO_RD.
  - FIFO_RD: register dst/dst_ch from FIFO dout (FIFO read latency is 1 cycle) and go DATA_READY.
  - DATA_READY: dst_val=1, dst/dst_ch stable. On dst_ack and reverse FIFO !full, push dst_ch and go IDLE. If the reverse FIFO is full, hold DATA_READY (cannot occur by depth sizing).
- dst_val is deasserted for at least 2 dst_clk cycles between deliveries.
- Ordering: deliveries follow grant order. Per channel, strictly one outstanding transfer.
- Latency (no contention): src_val to dst_val ≈ 2 src + async_fifo sync (2 dst) + 2 dst cycles; dst_ack to src_ack ≈ 1 dst + sync (2 src) + 2 src cycles.
- Simultaneous src_val on all channels: all are captured in the same cycle and delivered in round-robin order starting at the pointer.
- NUM_CH=1: the arbiter degenerates and dst_ch is constant 0.

Optional Feature:
CDC_HSK_MC_STATUS_EN:
- Defined: adds output src_busy[NUM_CH] (src_clk, 1 when channel c is in PEND or WAIT; reset 0). Also adds output dst_cnt[15:0] (dst_clk, count of completed deliveries, wraps at 65535→0; reset 0).
- Undefined: neither port exists and no counter logic is built.

Decomposition:
- Package cdc_hsk_mc_pkg: source state encodings (IDLE=0, PEND=1, WAIT=2), destination state encodings (IDLE=0, FIFO_RD=1, DATA_READY=2), and the clog2-based CH_W / FIFO_DEPTH_LOG2 helper function.
- One sub-module, rr_arbiter (NUM_CH request/grant, pointer update on accept).
- Both FIFOs instantiate the existing async_fifo.

Test Plan:
1. Single transfer, NUM_CH=4, WIDTH=8: src_val[2] for 1 cycle with slice2=0xA5 → dst_val with dst=0xA5, dst_ch=2; dst_ack → exactly one src_ack[2] pulse, other acks 0.
2. All four channels request at once (0x10,0x11,0x12,0x13), pointer=0 → deliveries in ch order 0,1,2,3 with matching data; each channel acked exactly once.
3. Back-pressure: hold dst_ack=0 for 50 dst cycles with 4 pending → dst stays stable; fwd FIFO never overflows; no src_ack until each ack.
4. Re-request: after src_ack[1], assert src_val[1]=0x3C next cycle → second delivery 0x3C on ch1. Holding src_val high continuously → one transfer per handshake, no duplicates.
5. Clock ratios src:dst = 1:3, 3:1, 1:1 asynchronous, 1000 random requests → scoreboard matches data/channel, per-channel order preserved, counts equal.
6. Assert rst mid-transfer (ch0 in WAIT) → all outputs 0 within reset; after release, no spurious dst_val/src_ack. With CDC_HSK_MC_STATUS_EN: src_busy=0 and dst_cnt=0.

Source files
------------

// File: rtl/cdc_hsk_mc_pkg.sv
// rtl/cdc_hsk_mc_pkg.sv - shared state encodings and sizing helper for cdc_handshake_mc
package cdc_hsk_mc_pkg;

  typedef enum logic [1:0] {
    SRC_IDLE = 2'd0,
    SRC_PEND = 2'd1,
    SRC_WAIT = 2'd2
  } src_state_e;

  typedef enum logic [1:0] {
    DST_IDLE       = 2'd0,
    DST_FIFO_RD    = 2'd1,
    DST_DATA_READY = 2'd2
  } dst_state_e;

  // ceil(log2(n)), never below 1 so single-channel builds still get a 1-bit id
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/async_fifo.sv
// rtl/async_fifo.sv - dual-clock FIFO, gray-coded pointers, registered read data (1-cycle latency)
module async_fifo #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          rst,
  input  logic          i_wr_clk,
  input  logic          i_wr_en,
  input  logic [DW-1:0] i_wr_data,
  output logic          o_full,
  input  logic          i_rd_clk,
  input  logic          i_rd_en,
  output logic [DW-1:0] o_rd_data,
  output logic          o_empty
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wbin, r_wgray, r_wq1_rgray, r_wq2_rgray;
  logic [AW:0]   r_rbin, r_rgray, r_rq1_wgray, r_rq2_wgray;
  logic [AW:0]   w_wbin_nxt, w_rbin_nxt, w_rbin_sync;
  logic          w_wr, w_rd;

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  assign w_wr        = i_wr_en && !o_full;
  assign w_rd        = i_rd_en && !o_empty;
  assign w_wbin_nxt  = r_wbin + (AW+1)'(w_wr);
  assign w_rbin_nxt  = r_rbin + (AW+1)'(w_rd);
  // Full compares in binary so the same check works for AW=1
  assign w_rbin_sync = gray2bin(r_wq2_rgray);
  assign o_full      = (r_wbin - w_rbin_sync) == (AW+1)'(DEPTH);
  assign o_empty     = (r_rgray == r_rq2_wgray);

  always_ff @(posedge i_wr_clk or posedge rst) begin
    if (rst) begin
      r_wbin      <= '0;
      r_wgray     <= '0;
      r_wq1_rgray <= '0;
      r_wq2_rgray <= '0;
    end else begin
      r_wbin      <= w_wbin_nxt;
      r_wgray     <= w_wbin_nxt ^ (w_wbin_nxt >> 1);
      r_wq1_rgray <= r_rgray;
      r_wq2_rgray <= r_wq1_rgray;
    end
  end

  always_ff @(posedge i_wr_clk) begin
    if (w_wr) r_mem[r_wbin[AW-1:0]] <= i_wr_data;
  end

  always_ff @(posedge i_rd_clk or posedge rst) begin
    if (rst) begin
      r_rbin      <= '0;
      r_rgray     <= '0;
      r_rq1_wgray <= '0;
      r_rq2_wgray <= '0;
      o_rd_data   <= '0;
    end else begin
      r_rbin      <= w_rbin_nxt;
      r_rgray     <= w_rbin_nxt ^ (w_rbin_nxt >> 1);
      r_rq1_wgray <= r_wgray;
      r_rq2_wgray <= r_rq1_wgray;
      if (w_rd) o_rd_data <= r_mem[r_rbin[AW-1:0]];
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, pointer moves past the winner only on accept
module rr_arbiter
  import cdc_hsk_mc_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = clog2_min1(N)
) (
  input  logic          i_clk,
  input  logic          rst,
  input  logic [N-1:0]  i_req,
  input  logic          i_accept,
  output logic          o_gnt_vld,
  output logic [IW-1:0] o_gnt_id
);

  logic [IW-1:0] r_ptr;

  // Scan from the farthest offset down so the requester nearest the pointer wins
  always_comb begin
    o_gnt_vld = 1'b0;
    o_gnt_id  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[(int'(r_ptr) + i) % N]) begin
        o_gnt_vld = 1'b1;
        o_gnt_id  = IW'((int'(r_ptr) + i) % N);
      end
    end
  end

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) r_ptr <= '0;
    else if (o_gnt_vld && i_accept) r_ptr <= IW'((int'(o_gnt_id) + 1) % N);
  end

endmodule

// File: rtl/cdc_handshake_mc.sv
// rtl/cdc_handshake_mc.sv - multi-channel src->dst handshake over shared async FIFOs; optional CDC_HSK_MC_STATUS_EN
module cdc_handshake_mc
  import cdc_hsk_mc_pkg::*;
#(
  parameter  int WIDTH           = 8,
  parameter  int NUM_CH          = 4,
  localparam int CH_W            = clog2_min1(NUM_CH),
  localparam int FIFO_DEPTH_LOG2 = clog2_min1(NUM_CH)
) (
  input  logic                    rst,
  input  logic                    src_clk,
  input  logic [NUM_CH*WIDTH-1:0] src,
  input  logic [NUM_CH-1:0]       src_val,
  output logic [NUM_CH-1:0]       src_ack,
  input  logic                    dst_clk,
  output logic [WIDTH-1:0]        dst,
  output logic [CH_W-1:0]         dst_ch,
  output logic                    dst_val,
  input  logic                    dst_ack
`ifdef CDC_HSK_MC_STATUS_EN
  , output logic [NUM_CH-1:0]     src_busy
  , output logic [15:0]           dst_cnt
`endif
);

  src_state_e             r_sstate [NUM_CH];
  src_state_e             w_snext  [NUM_CH];
  logic [WIDTH-1:0]       r_hold   [NUM_CH];
  logic [NUM_CH-1:0]      w_pend;
  logic                   w_gnt_vld;
  logic [CH_W-1:0]        w_gnt_id;
  logic                   w_fwd_full, w_fwd_wr, w_fwd_empty, w_fwd_rd;
  logic [CH_W+WIDTH-1:0]  w_fwd_wdata, w_fwd_rdata;
  logic                   w_rev_full, w_rev_wr, w_rev_empty, w_rev_rd;
  logic [CH_W-1:0]        w_rev_rdata;
  logic                   r_rev_vld;
  dst_state_e             r_dstate, w_dnext;

  assign w_fwd_wr    = w_gnt_vld && !w_fwd_full;
  assign w_fwd_wdata = {w_gnt_id, r_hold[w_gnt_id]};
  // Reverse FIFO alternates pop and consume, so r_rev_vld marks valid read data
  assign w_rev_rd    = !w_rev_empty && !r_rev_vld;

  always_ff @(posedge src_clk or posedge rst) begin
    if (rst) begin
      r_rev_vld <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_sstate[c] <= SRC_IDLE;
        r_hold[c]   <= '0;
      end
    end else begin
      r_rev_vld <= w_rev_rd;
      for (int c = 0; c < NUM_CH; c++) begin
        r_sstate[c] <= w_snext[c];
        if (r_sstate[c] == SRC_IDLE && src_val[c]) r_hold[c] <= src[c*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_snext[c] = r_sstate[c];
      case (r_sstate[c])
        SRC_IDLE: if (src_val[c]) w_snext[c] = SRC_PEND;
        SRC_PEND: if (w_fwd_wr && w_gnt_id == CH_W'(c)) w_snext[c] = SRC_WAIT;
        SRC_WAIT: if (r_rev_vld && w_rev_rdata == CH_W'(c)) w_snext[c] = SRC_IDLE;
        default:  w_snext[c] = SRC_IDLE;
      endcase
    end
  end

  always_comb begin
    w_pend  = '0;
    src_ack = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_pend[c]  = (r_sstate[c] == SRC_PEND);
      src_ack[c] = (r_sstate[c] == SRC_WAIT) && r_rev_vld && (w_rev_rdata == CH_W'(c));
    end
  end

`ifdef CDC_HSK_MC_STATUS_EN
  always_comb begin
    src_busy = '0;
    for (int c = 0; c < NUM_CH; c++) src_busy[c] = (r_sstate[c] != SRC_IDLE);
  end
`endif

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .i_clk     (src_clk),
    .rst       (rst),
    .i_req     (w_pend),
    .i_accept  (!w_fwd_full),
    .o_gnt_vld (w_gnt_vld),
    .o_gnt_id  (w_gnt_id)
  );

  async_fifo #(.DW(CH_W + WIDTH), .AW(FIFO_DEPTH_LOG2)) u_fwd_fifo (
    .rst       (rst),
    .i_wr_clk  (src_clk),
    .i_wr_en   (w_fwd_wr),
    .i_wr_data (w_fwd_wdata),
    .o_full    (w_fwd_full),
    .i_rd_clk  (dst_clk),
    .i_rd_en   (w_fwd_rd),
    .o_rd_data (w_fwd_rdata),
    .o_empty   (w_fwd_empty)
  );

  async_fifo #(.DW(CH_W), .AW(FIFO_DEPTH_LOG2)) u_rev_fifo (
    .rst       (rst),
    .i_wr_clk  (dst_clk),
    .i_wr_en   (w_rev_wr),
    .i_wr_data (dst_ch),
    .o_full    (w_rev_full),
    .i_rd_clk  (src_clk),
    .i_rd_en   (w_rev_rd),
    .o_rd_data (w_rev_rdata),
    .o_empty   (w_rev_empty)
  );

  always_ff @(posedge dst_clk or posedge rst) begin
    if (rst) r_dstate <= DST_IDLE;
    else     r_dstate <= w_dnext;
  end

  always_comb begin
    w_dnext = r_dstate;
    case (r_dstate)
      DST_IDLE:       if (!w_fwd_empty) w_dnext = DST_FIFO_RD;
      DST_FIFO_RD:    w_dnext = DST_DATA_READY;
      DST_DATA_READY: if (dst_ack && !w_rev_full) w_dnext = DST_IDLE;
      default:        w_dnext = DST_IDLE;
    endcase
  end

  always_comb begin
    w_fwd_rd = (r_dstate == DST_IDLE) && !w_fwd_empty;
    w_rev_wr = (r_dstate == DST_DATA_READY) && dst_ack && !w_rev_full;
    dst_val  = (r_dstate == DST_DATA_READY);
  end

  always_ff @(posedge dst_clk or posedge rst) begin
    if (rst) begin
      dst    <= '0;
      dst_ch <= '0;
`ifdef CDC_HSK_MC_STATUS_EN
      dst_cnt <= '0;
`endif
    end else begin
      if (r_dstate == DST_FIFO_RD) {dst_ch, dst} <= w_fwd_rdata;
`ifdef CDC_HSK_MC_STATUS_EN
      if (w_rev_wr) dst_cnt <= dst_cnt + 16'd1;
`endif
    end
  end

endmodule

// File: tb/tb_cdc_handshake_mc.sv
// tb/tb_cdc_handshake_mc.sv - scoreboard bench for cdc_handshake_mc (per-channel expected queues, ack bookkeeping)
`timescale 1ns/10ps
module tb_cdc_handshake_mc;

  localparam int NCH = 4;
  localparam int W   = 8;

  logic           rst, src_clk, dst_clk;
  logic [NCH*W-1:0] src;
  logic [NCH-1:0] src_val, src_ack;
  logic [W-1:0]   dst;
  logic [1:0]     dst_ch;
  logic           dst_val, dst_ack;
`ifdef CDC_HSK_MC_STATUS_EN
  logic [NCH-1:0] src_busy;
  logic [15:0]    dst_cnt;
`endif

  realtime src_half = 5.0;
  realtime dst_half = 5.0;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q [NCH][$];
  int           order_q[$];
  bit           busy     [NCH];
  int           pend_ack [NCH];
  int           ack_cnt  [NCH];
  int           dlv_cnt  [NCH];
  int           dlv_since_rst;
  int           ack_mode;
  logic [W-1:0] lat_d;
  logic [1:0]   lat_ch;
  logic         prev_val;

  cdc_handshake_mc #(.WIDTH(W), .NUM_CH(NCH)) dut (
    .rst     (rst),
    .src_clk (src_clk),
    .src     (src),
    .src_val (src_val),
    .src_ack (src_ack),
    .dst_clk (dst_clk),
    .dst     (dst),
    .dst_ch  (dst_ch),
    .dst_val (dst_val),
    .dst_ack (dst_ack)
`ifdef CDC_HSK_MC_STATUS_EN
    , .src_busy (src_busy)
    , .dst_cnt  (dst_cnt)
`endif
  );

  initial begin src_clk = 1'b0; forever #(src_half) src_clk = ~src_clk; end
  initial begin dst_clk = 1'b0; forever #(dst_half) dst_clk = ~dst_clk; end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sum_dlv();
    int s = 0;
    for (int c = 0; c < NCH; c++) s += dlv_cnt[c];
    return s;
  endfunction

  function automatic int sum_ack();
    int s = 0;
    for (int c = 0; c < NCH; c++) s += ack_cnt[c];
    return s;
  endfunction

  function automatic bit all_idle();
    for (int c = 0; c < NCH; c++)
      if (busy[c] || exp_q[c].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Destination-side monitor and consumer
  initial begin
    prev_val = 1'b0;
    dst_ack  = 1'b0;
    forever begin
      @(negedge dst_clk);
      if (rst) begin
        prev_val = 1'b0;
        dst_ack  = 1'b0;
      end else begin
        if (dst_val && !prev_val) begin
          if (exp_q[dst_ch].size() == 0) chk("unexpected_delivery", 32'(dst_ch), 32'hFF);
          else chk("dst_data", 32'(dst), 32'(exp_q[dst_ch].pop_front()));
          if (order_q.size() > 0) chk("dst_order", 32'(dst_ch), 32'(order_q.pop_front()));
          lat_d  = dst;
          lat_ch = dst_ch;
          dlv_cnt[dst_ch]++;
          dlv_since_rst++;
        end else if (dst_val) begin
          chk("dst_stable", 32'({dst_ch, dst}), 32'({lat_ch, lat_d}));
        end
        prev_val = dst_val;
        if (dst_val) begin
          dst_ack = (ack_mode == 1) || (ack_mode == 2 && $urandom_range(0, 1) == 1);
          if (dst_ack) pend_ack[dst_ch]++;
        end else begin
          dst_ack = 1'b0;
        end
      end
    end
  end

  // Source-side ack monitor
  initial begin
    forever begin
      @(negedge src_clk);
      if (!rst && src_ack != '0) begin
        chk("ack_onehot", 32'($countones(src_ack)), 32'd1);
        for (int c = 0; c < NCH; c++) begin
          if (src_ack[c]) begin
            chk("ack_expected", 32'(pend_ack[c] > 0), 32'd1);
            if (pend_ack[c] > 0) pend_ack[c]--;
            busy[c] = 1'b0;
            ack_cnt[c]++;
          end
        end
      end
    end
  end

  task automatic next_src();
    @(posedge src_clk);
    #1;
    src_val = '0;
  endtask

  task automatic issue(input int c, input logic [W-1:0] d);
    src[c*W +: W] = d;
    src_val[c]    = 1'b1;
    exp_q[c].push_back(d);
    busy[c] = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int n = 0;
    while (!all_idle() && n < max_cyc) begin
      next_src();
      n++;
    end
    chk(name, 32'(all_idle()), 32'd1);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    src_val = '0;
    repeat (3) @(negedge src_clk);
    chk("rst_src_ack", 32'(src_ack), 32'd0);
    chk("rst_dst_val", 32'(dst_val), 32'd0);
    chk("rst_dst",     32'(dst),     32'd0);
    chk("rst_dst_ch",  32'(dst_ch),  32'd0);
`ifdef CDC_HSK_MC_STATUS_EN
    chk("rst_src_busy", 32'(src_busy), 32'd0);
    chk("rst_dst_cnt",  32'(dst_cnt),  32'd0);
`endif
    for (int c = 0; c < NCH; c++) begin
      exp_q[c].delete();
      busy[c]     = 1'b0;
      pend_ack[c] = 0;
    end
    order_q.delete();
    dlv_since_rst = 0;
    @(negedge src_clk);
    rst = 1'b0;
  endtask

  task automatic run_random(input int n);
    int issued = 0;
    int guard  = 0;
    int d0, a0;
    d0 = sum_dlv();
    a0 = sum_ack();
    ack_mode = 2;
    while ((issued < n || !all_idle()) && guard < 50000) begin
      next_src();
      for (int c = 0; c < NCH; c++) begin
        if (issued < n && !busy[c] && $urandom_range(0, 2) == 0) begin
          issue(c, 8'($urandom));
          issued++;
        end
      end
      guard++;
    end
    next_src();
    chk("rand_done", 32'(guard < 50000), 32'd1);
    chk("rand_dlv",  32'(sum_dlv() - d0), 32'(n));
    chk("rand_ack",  32'(sum_ack() - a0), 32'(n));
`ifdef CDC_HSK_MC_STATUS_EN
    chk("rand_dst_cnt", 32'(dst_cnt), 32'(dlv_since_rst & 16'hFFFF));
`endif
  endtask

  initial begin
    int snap [NCH];
    int d0, a0, d1, a1, a_prev, n;
    bit done;
    src = '0;
    src_val = '0;
    ack_mode = 1;
    for (int c = 0; c < NCH; c++) begin
      busy[c] = 1'b0; pend_ack[c] = 0; ack_cnt[c] = 0; dlv_cnt[c] = 0;
    end
    do_reset();

    // Single transfer on channel 2
    for (int c = 0; c < NCH; c++) snap[c] = ack_cnt[c];
    next_src();
    issue(2, 8'hA5);
    order_q.push_back(2);
    next_src();
    wait_idle("t1_idle", 300);
    for (int c = 0; c < NCH; c++) chk("t1_ack_count", 32'(ack_cnt[c] - snap[c]), 32'(c == 2));

    // All channels at once from a fresh pointer
    do_reset();
    for (int c = 0; c < NCH; c++) snap[c] = ack_cnt[c];
    next_src();
    for (int c = 0; c < NCH; c++) begin
      issue(c, 8'(8'h10 + c));
      order_q.push_back(c);
    end
    next_src();
    wait_idle("t2_idle", 500);
    for (int c = 0; c < NCH; c++) chk("t2_ack_count", 32'(ack_cnt[c] - snap[c]), 32'd1);

    // Back-pressure with four pending
    ack_mode = 0;
    d0 = sum_dlv();
    a0 = sum_ack();
    next_src();
    for (int c = 0; c < NCH; c++) issue(c, 8'($urandom));
    next_src();
    repeat (50) @(negedge dst_clk);
    chk("t3_no_ack",   32'(sum_ack() - a0), 32'd0);
    chk("t3_one_dlv",  32'(sum_dlv() - d0), 32'd1);
    chk("t3_val_held", 32'(dst_val), 32'd1);
`ifdef CDC_HSK_MC_STATUS_EN
    chk("t3_busy", 32'(src_busy), 32'hF);
`endif
    ack_mode = 1;
    wait_idle("t3_idle", 500);
    chk("t3_acks", 32'(sum_ack() - a0), 32'd4);

    // Re-request on channel 1 the cycle after its ack
    d1 = dlv_cnt[1];
    next_src();
    issue(1, 8'h5A);
    next_src();
    n = 0;
    while (busy[1] && n < 300) begin
      @(posedge src_clk);
      #1;
      n++;
    end
    issue(1, 8'h3C);
    next_src();
    wait_idle("t4_idle", 300);
    chk("t4_rereq_dlv", 32'(dlv_cnt[1] - d1), 32'd2);

    // Continuous src_val on channel 1: one transfer per handshake
    d1 = dlv_cnt[1];
    a1 = ack_cnt[1];
    a_prev = a1;
    @(posedge src_clk);
    #1;
    issue(1, 8'h3C);
    n = 0;
    done = 1'b0;
    while (!done && n < 2000) begin
      @(posedge src_clk);
      #1;
      if (ack_cnt[1] != a_prev) begin
        a_prev = ack_cnt[1];
        if (ack_cnt[1] - a1 < 3) begin
          exp_q[1].push_back(8'h3C);
          busy[1] = 1'b1;
        end else begin
          src_val[1] = 1'b0;
          done = 1'b1;
        end
      end
      n++;
    end
    chk("t4_hold_done", 32'(done), 32'd1);
    repeat (40) next_src();
    wait_idle("t4_hold_idle", 300);
    chk("t4_hold_dlv", 32'(dlv_cnt[1] - d1), 32'd3);
    chk("t4_hold_ack", 32'(ack_cnt[1] - a1), 32'd3);

    // Random traffic across clock ratios
    src_half = 5.0;  dst_half = 15.0; run_random(340);
    src_half = 15.0; dst_half = 5.0;  run_random(330);
    src_half = 5.0;  dst_half = 5.35; run_random(330);

    // Reset while channel 0 waits for its ack
    ack_mode = 0;
    next_src();
    issue(0, 8'hC3);
    next_src();
    repeat (20) @(negedge dst_clk);
    chk("t6_delivered", 32'(dst_val), 32'd1);
    #3;
    do_reset();
    d0 = sum_dlv();
    a0 = sum_ack();
    ack_mode = 1;
    repeat (100) next_src();
    chk("t6_no_dlv", 32'(sum_dlv() - d0), 32'd0);
    chk("t6_no_ack", 32'(sum_ack() - a0), 32'd0);
    chk("t6_dst_val", 32'(dst_val), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
